ex_operand_stage: RTL and testbench

- Pipeline register and operand-formation stage directly upstream of the ALU.
- Each cycle it accepts one decoded instruction from decode/regfile read, resolves data hazards by forwarding from EX/MEM and MEM/WB, and forms the two 32-bit ALU operands (register, immediate variants, or shift amount).
- It holds the result in a registered slot under a valid/ready handshake, so the ALU and downstream logic see stable porta/portb/aluop while stalled.

---
 rtl/ex_operand_stage_if.sv | 52 +++++
 rtl/ex_operand_stage.sv | 153 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Handshake and operand bus between decode/forwarding sources and the EX operand stage.
// The stage uses the slave modport; the producer/consumer side uses master.
interface ex_operand_stage_if #(
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   rs_data;
  logic [DW-1:0]   rt_data;
  logic [4:0]      rs_idx;
  logic [4:0]      rt_idx;
  logic [15:0]     imm16;
  logic [4:0]      shamt;
  logic [1:0]      alusrc;
  logic            shift_sel;
  logic [3:0]      aluop_in;
  logic            wr_en_in;
  logic [4:0]      wr_idx_in;
  logic            exmem_wen;
  logic [4:0]      exmem_idx;
  logic [DW-1:0]   exmem_data;
  logic            memwb_wen;
  logic [4:0]      memwb_idx;
  logic [DW-1:0]   memwb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   porta;
  logic [DW-1:0]   portb;
  logic [DW-1:0]   store_data;
  logic [3:0]      aluop;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output in_valid, rs_data, rt_data, rs_idx, rt_idx, imm16, shamt, alusrc,
           shift_sel, aluop_in, wr_en_in, wr_idx_in, exmem_wen, exmem_idx,
           exmem_data, memwb_wen, memwb_idx, memwb_data, flush, out_ready,
    input  in_ready, out_valid, porta, portb, store_data, aluop, wr_en,
           wr_idx, stall_cnt
  );

  modport slave (
    input  in_valid, rs_data, rt_data, rs_idx, rt_idx, imm16, shamt, alusrc,
           shift_sel, aluop_in, wr_en_in, wr_idx_in, exmem_wen, exmem_idx,
           exmem_data, memwb_wen, memwb_idx, memwb_data, flush, out_ready,
    output in_ready, out_valid, porta, portb, store_data, aluop, wr_en,
           wr_idx, stall_cnt
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Operand-formation pipeline slot in front of the ALU: forwards rs/rt from EX/MEM and
// MEM/WB, builds porta/portb, and holds them stable under a valid/ready handshake.
module ex_operand_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input logic             CLK,
  input logic             RST,
  ex_operand_stage_if.slave bus
);

  localparam logic [0:0]      ST_EMPTY = 1'b0;
  localparam logic [0:0]      ST_FULL  = 1'b1;
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [0:0]      r_state;
  logic [DW-1:0]   r_porta;
  logic [DW-1:0]   r_portb;
  logic [DW-1:0]   r_store_data;
  logic [3:0]      r_aluop;
  logic            r_wr_en;
  logic [4:0]      r_wr_idx;
  logic [CNTW-1:0] r_stall_cnt;

  logic [0:0]      w_state_nx;
  logic            w_out_valid;
  logic            w_in_ready;
  logic            w_accept;
  logic [DW-1:0]   w_fwd_rs;
  logic [DW-1:0]   w_fwd_rt;
  logic [DW-1:0]   w_porta;
  logic [DW-1:0]   w_portb;

  // EX/MEM is the younger producer, so it takes priority; r0 is hardwired to zero.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [4:0]    idx,
    input logic [DW-1:0] rf_data,
    input logic          ex_wen,
    input logic [4:0]    ex_idx,
    input logic [DW-1:0] ex_data,
    input logic          wb_wen,
    input logic [4:0]    wb_idx,
    input logic [DW-1:0] wb_data
  );
    logic [DW-1:0] v;
    if (idx == 5'd0) begin
      v = {DW{1'b0}};
    end else if (ex_wen && (ex_idx == idx)) begin
      v = ex_data;
    end else if (wb_wen && (wb_idx == idx)) begin
      v = wb_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  assign w_out_valid = (r_state == ST_FULL);
  assign w_in_ready  = !w_out_valid || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;

  assign w_fwd_rs = fwd_sel(bus.rs_idx, bus.rs_data, bus.exmem_wen, bus.exmem_idx,
                            bus.exmem_data, bus.memwb_wen, bus.memwb_idx, bus.memwb_data);
  assign w_fwd_rt = fwd_sel(bus.rt_idx, bus.rt_data, bus.exmem_wen, bus.exmem_idx,
                            bus.exmem_data, bus.memwb_wen, bus.memwb_idx, bus.memwb_data);

  // Operand formation for the instruction being offered this cycle.
  always_comb begin
    w_porta = {DW{1'b0}};
    w_portb = {DW{1'b0}};
    if (bus.shift_sel) begin
      w_porta = {{(DW-5){1'b0}}, bus.shamt};
    end else begin
      w_porta = w_fwd_rs;
    end
    case (bus.alusrc)
      2'b00:   w_portb = w_fwd_rt;
      2'b01:   w_portb = {{(DW-16){bus.imm16[15]}}, bus.imm16};
      2'b10:   w_portb = {{(DW-16){1'b0}}, bus.imm16};
      2'b11:   w_portb = DW'({bus.imm16, 16'h0000});
      default: w_portb = {DW{1'b0}};
    endcase
  end

  // Slot occupancy: flush beats accept, accept beats consume (no bubble on replace).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nx = ST_FULL;
        end else begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          w_state_nx = ST_EMPTY;
        end else if (w_accept) begin
          w_state_nx = ST_FULL;
        end else if (bus.out_ready) begin
          w_state_nx = ST_EMPTY;
        end else begin
          w_state_nx = ST_FULL;
        end
      end
      default: w_state_nx = ST_EMPTY;
    endcase
  end

  // Slot state and payload; payload only moves on accept so it is frozen while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_EMPTY;
      r_porta      <= {DW{1'b0}};
      r_portb      <= {DW{1'b0}};
      r_store_data <= {DW{1'b0}};
      r_aluop      <= 4'd0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= 5'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_porta      <= w_porta;
        r_portb      <= w_portb;
        r_store_data <= w_fwd_rt;
        r_aluop      <= bus.aluop_in;
        r_wr_en      <= bus.wr_en_in;
        r_wr_idx     <= bus.wr_idx_in;
      end
    end
  end

  // Back-pressure statistic; survives flush, saturates rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= {CNTW{1'b0}};
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.porta      = r_porta;
  assign bus.portb      = r_portb;
  assign bus.store_data = r_store_data;
  assign bus.aluop      = r_aluop;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_idx     = r_wr_idx;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed plus randomized bench for ex_operand_stage, checked against a
// transaction-level slot model (one optional instruction plus a stall counter).
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.DW(32), .CNTW(16)) bus ();
  ex_operand_stage #(.DW(32), .CNTW(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // reference slot
  logic        m_valid = 1'b0;
  logic [31:0] m_porta = 32'd0, m_portb = 32'd0, m_store = 32'd0;
  logic [3:0]  m_aluop = 4'd0;
  logic        m_wr_en = 1'b0;
  logic [4:0]  m_wr_idx = 5'd0;
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (bus.exmem_wen && bus.exmem_idx == idx) return bus.exmem_data;
    if (bus.memwb_wen && bus.memwb_idx == idx) return bus.memwb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_portb();
    logic [31:0] imm;
    imm = 32'(bus.imm16);
    case (bus.alusrc)
      2'd0:    return ref_fwd(bus.rt_idx, bus.rt_data);
      2'd1:    return (bus.imm16[15]) ? imm - 32'h0001_0000 : imm;
      2'd2:    return imm;
      default: return imm * 32'd65536;
    endcase
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
    bus.rs_idx = 5'd0; bus.rt_idx = 5'd0; bus.imm16 = 16'd0; bus.shamt = 5'd0;
    bus.alusrc = 2'd0; bus.shift_sel = 1'b0; bus.aluop_in = 4'd0;
    bus.wr_en_in = 1'b0; bus.wr_idx_in = 5'd0; bus.exmem_wen = 1'b0;
    bus.exmem_idx = 5'd0; bus.exmem_data = 32'd0; bus.memwb_wen = 1'b0;
    bus.memwb_idx = 5'd0; bus.memwb_data = 32'd0; bus.flush = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic cycle();
    logic rdy, acc;
    @(negedge clk);
    rdy = !m_valid || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    acc = bus.in_valid && rdy && !bus.flush;
    if (rst) begin
      m_valid = 1'b0; m_porta = 32'd0; m_portb = 32'd0; m_store = 32'd0;
      m_aluop = 4'd0; m_wr_en = 1'b0; m_wr_idx = 5'd0; m_stall = 0;
    end else begin
      if (m_valid && !bus.out_ready && m_stall < 65535) m_stall++;
      if (bus.flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid  = 1'b1;
        m_porta  = bus.shift_sel ? 32'(bus.shamt) : ref_fwd(bus.rs_idx, bus.rs_data);
        m_portb  = ref_portb();
        m_store  = ref_fwd(bus.rt_idx, bus.rt_data);
        m_aluop  = bus.aluop_in;
        m_wr_en  = bus.wr_en_in;
        m_wr_idx = bus.wr_idx_in;
      end else if (bus.out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    if (m_valid) begin
      chk("porta", 64'(bus.porta), 64'(m_porta));
      chk("portb", 64'(bus.portb), 64'(m_portb));
      chk("store_data", 64'(bus.store_data), 64'(m_store));
      chk("aluop", 64'(bus.aluop), 64'(m_aluop));
      chk("wr_en", 64'(bus.wr_en), 64'(m_wr_en));
      chk("wr_idx", 64'(bus.wr_idx), 64'(m_wr_idx));
    end
  endtask

  initial begin
    int saved_stall;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(); cycle();
    chk("rst_porta", 64'(bus.porta), 64'd0);
    chk("rst_portb", 64'(bus.portb), 64'd0);
    chk("rst_store", 64'(bus.store_data), 64'd0);
    chk("rst_ctl", 64'({bus.aluop, bus.wr_en, bus.wr_idx}), 64'd0);
    rst = 1'b0;
    cycle();

    // immediate forms
    bus.in_valid = 1'b1; bus.rs_idx = 5'd1; bus.rs_data = 32'd5; bus.imm16 = 16'hFFFC;
    bus.alusrc = 2'b01; cycle();
    chk("imm_sext", 64'(bus.portb), 64'hFFFF_FFFC);
    chk("imm_rs", 64'(bus.porta), 64'd5);
    bus.alusrc = 2'b10; cycle();
    chk("imm_zext", 64'(bus.portb), 64'h0000_FFFC);
    bus.alusrc = 2'b11; cycle();
    chk("imm_hi", 64'(bus.portb), 64'hFFFC_0000);

    // forwarding priority
    bus.alusrc = 2'b00; bus.rs_idx = 5'd8; bus.rt_idx = 5'd8;
    bus.rs_data = 32'h1111; bus.rt_data = 32'h2222;
    bus.exmem_wen = 1'b1; bus.exmem_idx = 5'd8; bus.exmem_data = 32'hAAAA;
    bus.memwb_wen = 1'b1; bus.memwb_idx = 5'd8; bus.memwb_data = 32'hBBBB;
    cycle();
    chk("fwd_ex_a", 64'(bus.porta), 64'hAAAA);
    chk("fwd_ex_b", 64'(bus.portb), 64'hAAAA);
    bus.exmem_wen = 1'b0; cycle();
    chk("fwd_wb_a", 64'(bus.porta), 64'hBBBB);
    chk("fwd_wb_st", 64'(bus.store_data), 64'hBBBB);
    bus.exmem_wen = 1'b1; bus.rs_idx = 5'd0; bus.exmem_idx = 5'd0; bus.memwb_idx = 5'd0;
    bus.rs_data = 32'hDEAD_BEEF; cycle();
    chk("fwd_r0", 64'(bus.porta), 64'd0);

    // stall / hold
    idle(); bus.in_valid = 1'b1; bus.rs_idx = 5'd3; bus.rs_data = 32'd3;
    bus.aluop_in = 4'h2; bus.wr_en_in = 1'b1; bus.wr_idx_in = 5'd9; cycle();
    bus.out_ready = 1'b0; bus.rs_data = 32'd77; bus.aluop_in = 4'h5; bus.wr_idx_in = 5'd4;
    repeat (4) cycle();
    chk("hold_porta", 64'(bus.porta), 64'd3);
    chk("hold_aluop", 64'(bus.aluop), 64'h2);
    chk("hold_ready", 64'(bus.in_ready), 64'd0);
    chk("hold_stall", 64'(bus.stall_cnt), 64'd4);
    bus.out_ready = 1'b1; cycle();
    chk("replace_porta", 64'(bus.porta), 64'd77);
    chk("replace_valid", 64'(bus.out_valid), 64'd1);

    // flush drops held and incoming instructions, keeps stall_cnt
    saved_stall = m_stall;
    bus.flush = 1'b1; bus.rs_data = 32'd55; cycle();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_stall", 64'(bus.stall_cnt), 64'(saved_stall));
    bus.flush = 1'b0; bus.in_valid = 1'b0; cycle();

    // shift amount
    bus.in_valid = 1'b1; bus.shift_sel = 1'b1; bus.shamt = 5'd31;
    bus.rs_idx = 5'd2; bus.rs_data = 32'hFFFF_FFFF; cycle();
    chk("shamt", 64'(bus.porta), 64'd31);

    // reset mid-stall discards the slot
    bus.shift_sel = 1'b0; bus.out_ready = 1'b0; cycle(); cycle();
    rst = 1'b1; cycle();
    chk("rst_stall_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    rst = 1'b0; idle(); cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.rs_idx     = 5'($urandom_range(0, 3));
      bus.rt_idx     = 5'($urandom_range(0, 3));
      bus.rs_data    = $urandom; bus.rt_data = $urandom;
      bus.imm16      = 16'($urandom); bus.shamt = 5'($urandom);
      bus.alusrc     = 2'($urandom); bus.shift_sel = ($urandom_range(0, 3) == 0);
      bus.aluop_in   = 4'($urandom); bus.wr_en_in = 1'($urandom);
      bus.wr_idx_in  = 5'($urandom);
      bus.exmem_wen  = 1'($urandom); bus.exmem_idx = 5'($urandom_range(0, 3));
      bus.exmem_data = $urandom;
      bus.memwb_wen  = 1'($urandom); bus.memwb_idx = 5'($urandom_range(0, 3));
      bus.memwb_data = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
